// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory interface: word-organised storage
// behind a request/ready handshake with programmable wait states, byte strobes and error pulses.
module data_mem_responder #(
  parameter int ADDR_W  = 15,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0]  LAT     = 4'(LATENCY);
  // Address bits that fall outside the storage span; empty when ADDR_W covers the full bus.
  localparam logic [31:0] HI_MASK = ~((32'h1 << (ADDR_W + 2)) - 32'h1);

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                ready_nxt, err_nxt;
  logic                rd_en, wr_en;

  logic                req_write;
  logic                req_err;
  logic [ADDR_W-1:0]   req_idx;
  logic [31:0]         req_wdata;
  logic [3:0]          req_wstrb;

  logic                accept;
  logic                acc_err;
  logic [ADDR_W-1:0]   rd_idx;

  logic [31:0]         storage [2**ADDR_W];

  assign accept  = (state == S_IDLE) && (mem_read || mem_write);
  assign acc_err = (mem_read && mem_write) || (mem_addr[1:0] != 2'b00) ||
                   ((mem_addr & HI_MASK) != 32'h0);

  // With zero wait states the read is issued on the accept edge, before the latch is valid.
  assign rd_idx = (state == S_IDLE) ? mem_addr[ADDR_W+1:2] : req_idx;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt = LAT;
          if (LAT == 4'd0) begin
            state_nxt = S_RESP;
            ready_nxt = 1'b1;
            err_nxt   = acc_err;
            rd_en     = !acc_err && !mem_write;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = S_RESP;
          ready_nxt = 1'b1;
          err_nxt   = req_err;
          rd_en     = !req_write && !req_err;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        wr_en     = req_write && !req_err;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      req_write <= 1'b0;
      req_err   <= 1'b0;
      req_idx   <= '0;
      req_wdata <= 32'h0;
      req_wstrb <= 4'h0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_ready <= ready_nxt;
      mem_err   <= err_nxt;
      if (accept) begin
        req_write <= mem_write;
        req_err   <= acc_err;
        req_idx   <= mem_addr[ADDR_W+1:2];
        req_wdata <= mem_wdata;
        req_wstrb <= mem_wstrb;
      end
    end
  end

  // Read data only moves on a successful read response; writes and errors leave it alone.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      mem_rdata <= 32'h0;
    end else if (rd_en) begin
      mem_rdata <= storage[rd_idx];
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM and survives a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) storage[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for handshake, strobes,
// errors and reset; a LATENCY=0 instance for back-to-back throughput.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready, mem_err;

  logic        z_read, z_write;
  logic [31:0] z_addr, z_wdata;
  logic [3:0]  z_wstrb;
  logic [31:0] z_rdata;
  logic        z_ready, z_err;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_rd  = 32'h0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(15), .LATENCY(LAT)) u_dut (
    .clk(clk), .rstn(rstn),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  data_mem_responder #(.ADDR_W(15), .LATENCY(0)) u_dut_z (
    .clk(clk), .rstn(rstn),
    .mem_read(z_read), .mem_write(z_write), .mem_addr(z_addr),
    .mem_wdata(z_wdata), .mem_wstrb(z_wstrb),
    .mem_rdata(z_rdata), .mem_ready(z_ready), .mem_err(z_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Called with the request already on the bus and `start` edges already elapsed since it was driven.
  task automatic wait_ready(input string tag, input int start, input logic exp_err);
    int cycles = start;
    bit seen   = 1'b0;
    while (!seen && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (mem_ready) seen = 1'b1;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check({tag, "/latency"}, 32'(cycles), 32'(LAT + 1));
    check({tag, "/err"},     {31'h0, mem_err}, {31'h0, exp_err});
    check({tag, "/rdata"},   mem_rdata, last_rd);
    @(posedge clk); #1;
    check({tag, "/pulse"},   {31'h0, mem_ready}, 32'h0);
  endtask

  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic exp_err,
                        input logic [31:0] exp_data);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    if (rd && !wr && !exp_err) last_rd = exp_data;
    wait_ready(tag, 0, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] zvals [4];
    int          k;
    zvals = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};

    rstn = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    z_read = 1'b0; z_write = 1'b0; z_addr = 32'h0; z_wdata = 32'h0; z_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/rdata", mem_rdata, 32'h0);
    check("reset/ready", {31'h0, mem_ready}, 32'h0);
    check("reset/err",   {31'h0, mem_err}, 32'h0);
    @(negedge clk) rstn = 1'b0;
    @(posedge clk); #1;

    // Basic write then read
    access("t1_wr", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    access("t1_rd", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);

    // Byte lanes and the zero-strobe no-op
    access("t2_wr_full", 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF,    1'b0, 32'h0);
    access("t2_wr_lane", 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0);
    access("t2_rd",      1'b1, 1'b0, 32'h20, 32'h0,        4'h0,    1'b0, 32'h11BB33DD);
    access("t2_wr_none", 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0,    1'b0, 32'h0);
    access("t2_rd_none", 1'b1, 1'b0, 32'h20, 32'h0,        4'h0,    1'b0, 32'h11BB33DD);

    // Errors: rdata must keep 0x11BB33DD, storage must not change
    access("t3_rd_mis",  1'b1, 1'b0, 32'h0000_0022, 32'h0,        4'h0, 1'b1, 32'h0);
    access("t3_rd_hi",   1'b1, 1'b0, 32'h0002_0010, 32'h0,        4'h0, 1'b1, 32'h0);
    access("t3_both",    1'b1, 1'b1, 32'h0000_0010, 32'h0,        4'hF, 1'b1, 32'h0);
    access("t3_wr_hi",   1'b0, 1'b1, 32'h0002_0020, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
    access("t3_wr_mis",  1'b0, 1'b1, 32'h0000_0011, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
    access("t3_rd_10",   1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
    access("t3_rd_20",   1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h11BB33DD);

    // Request altered after acceptance
    mem_write = 1'b1; mem_read = 1'b0; mem_addr = 32'h40; mem_wdata = 32'h5; mem_wstrb = 4'hF;
    @(posedge clk); #1;
    mem_wdata = 32'h9; mem_write = 1'b0; mem_addr = 32'h44; mem_wstrb = 4'h0;
    wait_ready("t4_wr", 1, 1'b0);
    access("t4_rd", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h5);

    // Reset during WAIT discards the pending write
    access("t5_pre", 1'b0, 1'b1, 32'h50, 32'h1, 4'hF, 1'b0, 32'h0);
    mem_write = 1'b1; mem_addr = 32'h50; mem_wdata = 32'h77; mem_wstrb = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rstn = 1'b1;
    mem_write = 1'b0;
    #1;
    check("t5_rst/rdata", mem_rdata, 32'h0);
    check("t5_rst/ready", {31'h0, mem_ready}, 32'h0);
    check("t5_rst/err",   {31'h0, mem_err}, 32'h0);
    last_rd = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b0;
    @(posedge clk); #1;
    access("t5_rd", 1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0, 32'h1);

    // LATENCY=0 instance: preload, then held-high back-to-back reads
    z_write = 1'b1; z_wstrb = 4'hF; z_addr = 32'h0; z_wdata = zvals[0];
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(posedge clk); #1;
      if (z_ready) begin
        k++;
        if (k < 4) begin
          z_addr  = 32'(k * 4);
          z_wdata = zvals[k];
        end else begin
          z_write = 1'b0;
        end
      end
    end
    z_write = 1'b0;
    check("t6_wr_count", 32'(k), 32'd4);
    @(posedge clk); #1;

    z_read = 1'b1; z_addr = 32'h0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("t6_ready_%0d", c), {31'h0, z_ready}, {31'h0, ((c % 2) == 0)});
      if (z_ready) begin
        check($sformatf("t6_rdata_%0d", k), z_rdata, zvals[k % 4]);
        check($sformatf("t6_err_%0d", k), {31'h0, z_err}, 32'h0);
        k++;
        z_addr = 32'(k * 4);
      end
    end
    z_read = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (slave) end of the core's data-memory request interface: mem_read/mem_write/mem_addr/mem_wdata in, mem_rdata out.
- Adds a completion handshake (mem_ready), programmable wait states, byte-lane write strobes and error signalling.
- Owns a word-organised storage array, so it can stand in for the single-cycle block RAM behind the datapath.
- Used for multi-cycle memory bring-up and for exercising datapath stall logic.

Parameters:
ADDR_W, 15, word-address width; storage depth = 2^ADDR_W 32-bit words (byte span 2^(ADDR_W+2)).
LATENCY, 2, wait states between request acceptance and response; legal range 0..15.

Ports:
clk        input   1   clock; all state updates on rising edge.
rstn       input   1   reset, asynchronous, active-high (1 = reset asserted).
mem_read   input   1   read request.
mem_write  input   1   write request.
mem_addr   input   32  byte address of the request.
mem_wdata  input   32  write data.
mem_wstrb  input   4   byte-lane write enables; bit i enables mem_wdata[8i+7:8i].
mem_rdata  output  32  read data; valid while mem_ready=1 for a read.
mem_ready  output  1   one-cycle completion pulse.
mem_err    output  1   one-cycle error pulse, coincident with mem_ready.

Behaviour:
- Reset (async, any state): FSM=IDLE, wait counter=0, mem_ready=0, mem_err=0, mem_rdata=0, latched request cleared, pending write discarded. Storage contents are not reset and persist across reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE -> accept on any edge where mem_read|mem_write=1:
  - latch op, addr, wdata, wstrb;
  - load counter with LATENCY;
  - go to WAIT if LATENCY>0, otherwise directly to RESP.
- WAIT: counter decrements each cycle; at the edge where the counter equals 1, go to RESP. Accept-to-ready latency is exactly LATENCY+1 cycles.
- RESP (exactly one cycle):
  - mem_ready=1.
  - Read: mem_rdata = storage[addr[ADDR_W+1:2]].
  - Write: the strobed lanes commit at the RESP clock edge.
  - Next state is IDLE. A new request is accepted no earlier than the cycle after RESP, so sustained throughput is one access per LATENCY+2 cycles.
- Inputs are sampled only at acceptance. Changes or deassertion after acceptance are ignored and the transaction completes with the latched values. The initiator holds the request until it sees mem_ready, then drops it or presents the next one.
- Error conditions, checked at acceptance:
  - mem_read and mem_write both 1;
  - addr[1:0] != 0;
  - any addr bit above ADDR_W+1 set.
- Error handling:
  - Full latency is still observed; RESP asserts mem_ready=1 and mem_err=1.
  - No storage access occurs and mem_rdata keeps its previous value.
- mem_wstrb=4'b0000 write: legal no-op, normal response, mem_err=0.
- mem_rdata holds the last successful read data until the next successful read response. Write responses and error responses do not change it.
- mem_ready and mem_err are registered outputs, low in IDLE and WAIT.
- Storage: synchronous read and write, single port, inferable as block RAM. Read data is registered into mem_rdata at the WAIT->RESP transition edge; for LATENCY=0 this is the IDLE->RESP edge.

Test Plan:
1. LATENCY=2: write 0xDEADBEEF to 0x10, strb 4'hF, then read 0x10 -> mem_ready pulses 3 cycles after each accept; read gives mem_rdata=0xDEADBEEF, mem_err=0.
2. Byte lanes: write 0x11223344 strb F to 0x20, then 0xAABBCCDD strb 4'b0101, then read 0x20 -> 0x11BB33DD.
3. Errors: read 0x22 (misaligned); read with addr bit ADDR_W+2 set; mem_read=mem_write=1 -> each gives mem_ready=mem_err=1 after LATENCY+1 cycles, mem_rdata unchanged, no storage change.
4. Request changed mid-flight: accept a write of 0x5 to 0x40, then change mem_wdata to 0x9 and drop mem_write during WAIT -> read 0x40 returns 0x00000005.
5. Reset mid-operation: assert rstn during WAIT of a write of 0x77 to 0x50 whose location holds 0x1 -> outputs 0 immediately (async), FSM IDLE; a subsequent read of 0x50 returns 0x00000001.
6. LATENCY=0 back-to-back reads held high continuously -> mem_ready pulses every 2nd cycle, each with correct data.
